// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressed little-endian data RAM with a valid/ready
//               request port. It supports byte/half/word(/dword) accesses,
//               sign- or zero-extended loads, registered read data and
//               range/size error reporting.
//               Build option DMEM_MISALIGN_EN: when defined, a misaligned
//               access that crosses a row is split into two beats by a small
//               IDLE/SPLIT FSM. When undefined, any misaligned access is
//               reported as an error and req_ready is tied high.
// Ports       : clk, rst_n (async, active-low)
//               cs, req_valid, req_ready    - request handshake
//               we, size, sign_ext, addr, wdata - request payload
//               rsp_valid, rdata, err       - one-cycle response strobe + data
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int ROWS  = DEPTH / LANES;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] mem_q [ROWS];

    // Context of a split access, held for its second beat.
    logic [LB-1:0]     lane0_q;
    logic [ROW_W-1:0]  row1_q;
    logic [3:0]        nbytes_q;
    logic              we_q;
    logic              sext_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_q;     // load bytes gathered in the first beat

    logic              rsp_valid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [3:0]        w_nbytes;
    logic [ADDR_W:0]   w_last;
    logic              w_in_range;
    logic              w_size_ok;
    logic              w_legal;
    logic              w_accept;
    logic              w_go_split;
    logic              w_in_split;
    logic [ROW_W-1:0]  w_row0;

    assign w_nbytes   = 4'd1 << size;
    // Last byte address computed one bit wider so that high addresses never wrap.
    assign w_last     = {1'b0, addr} + (ADDR_W+1)'(w_nbytes) - (ADDR_W+1)'(1);
    assign w_in_range = (w_last < (ADDR_W+1)'(DEPTH));
    assign w_size_ok  = ({30'd0, size} <= 32'(LB));
    assign w_row0     = addr[LB +: ROW_W];
    assign w_in_split = (state_q == SPLIT);

`ifdef DMEM_MISALIGN_EN
    logic [LB+1:0] w_span_end;
    assign w_span_end = (LB+2)'(addr[LB-1:0]) + (LB+2)'(w_nbytes);
    assign w_legal    = w_size_ok & w_in_range;
    assign w_go_split = w_accept & w_legal & (w_span_end > (LB+2)'(LANES));
    assign req_ready  = ~w_in_split;
`else
    // Without split support the FSM never leaves IDLE and collapses away.
    logic [LB-1:0] w_mis;
    assign w_mis      = addr[LB-1:0] & (w_nbytes[LB-1:0] - LB'(1));
    assign w_legal    = w_size_ok & w_in_range & (w_mis == '0);
    assign w_go_split = 1'b0;
    assign req_ready  = 1'b1;
`endif

    assign w_accept = cs & req_valid & req_ready;

    // ------------------------------------------------------------------
    // Current beat context: live request in IDLE, saved request in SPLIT
    // ------------------------------------------------------------------
    logic [LB-1:0]     w_cur_lane0;
    logic [ROW_W-1:0]  w_cur_row;
    logic [3:0]        w_cur_nbytes;
    logic              w_cur_we;
    logic              w_cur_sext;
    logic [DATA_W-1:0] w_cur_wdata;

    always_comb begin
        if (w_in_split) begin
            w_cur_lane0  = lane0_q;
            w_cur_row    = row1_q;
            w_cur_nbytes = nbytes_q;
            w_cur_we     = we_q;
            w_cur_sext   = sext_q;
            w_cur_wdata  = wdata_q;
        end else begin
            w_cur_lane0  = addr[LB-1:0];
            w_cur_row    = w_row0;
            w_cur_nbytes = w_nbytes;
            w_cur_we     = we;
            w_cur_sext   = sign_ext;
            w_cur_wdata  = wdata;
        end
    end

    // ------------------------------------------------------------------
    // Byte k of the access lives in lane (lane0 + k). A carry out of the
    // lane field means the byte belongs to the next row, i.e. the second
    // beat; otherwise it belongs to the first (or only) beat.
    // ------------------------------------------------------------------
    logic [LB:0]       w_lane_full [LANES];
    logic [LANES-1:0]  w_act;
    logic [DATA_W-1:0] w_row_data;
    logic [DATA_W-1:0] w_asm;
    logic [DATA_W-1:0] w_ext;
    logic              w_sign;

    always_comb begin
        w_act      = '0;
        w_row_data = mem_q[w_cur_row];
        w_asm      = rbuf_q;
        w_ext      = '0;
        w_sign     = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_full[k] = (LB+1)'(k) + {1'b0, w_cur_lane0};
            w_act[k]       = (k < int'(w_cur_nbytes)) && (w_lane_full[k][LB] == w_in_split);
            if (w_act[k]) begin
                w_asm[8*k +: 8] = w_row_data[8*w_lane_full[k][LB-1:0] +: 8];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            if (k == int'(w_cur_nbytes) - 1) begin
                w_sign = w_asm[8*k+7];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            w_ext[8*k +: 8] = (k < int'(w_cur_nbytes)) ? w_asm[8*k +: 8]
                                                       : {8{w_cur_sext & w_sign}};
        end
    end

    // ------------------------------------------------------------------
    // Storage write: the bytes active in this beat of a legal store
    // ------------------------------------------------------------------
    logic w_mem_we;
    assign w_mem_we = w_cur_we & (w_in_split | (w_accept & w_legal));

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_act[k]) begin
                    mem_q[w_cur_row][8*w_lane_full[k][LB-1:0] +: 8] <= w_cur_wdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (w_go_split) state_d = SPLIT;
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Response and split context registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            lane0_q     <= '0;
            row1_q      <= '0;
            nbytes_q    <= '0;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (w_in_split) begin
                rsp_valid_q <= 1'b1;
                err_q       <= 1'b0;
                rdata_q     <= w_cur_we ? '0 : w_ext;
            end else if (w_accept) begin
                if (!w_legal) begin
                    rsp_valid_q <= 1'b1;
                    err_q       <= 1'b1;
                    rdata_q     <= '0;
                end else if (w_go_split) begin
                    lane0_q  <= addr[LB-1:0];
                    row1_q   <= w_row0 + ROW_W'(1);
                    nbytes_q <= w_nbytes;
                    we_q     <= we;
                    sext_q   <= sign_ext;
                    wdata_q  <= wdata;
                    rbuf_q   <= w_asm;
                end else begin
                    rsp_valid_q <= 1'b1;
                    err_q       <= 1'b0;
                    rdata_q     <= we ? '0 : w_ext;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl (DATA_W=32, DEPTH=256).
//               A byte-array reference model predicts legality, latency and
//               load data; directed scenarios plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              we = 1'b0;
    logic [1:0]        size = 2'd0;
    logic              sign_ext = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .req_valid(req_valid), .req_ready(req_ready),
        .we(we), .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rdata(rdata), .err(err)
    );

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
        longint la;
        longint nb;
        la = longint'(a);
        nb = longint'(1) << sz;
        if (sz > 2) return 1'b0;
        if (la + nb - 1 >= DEPTH) return 1'b0;
`ifndef DMEM_MISALIGN_EN
        if ((la % nb) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic int m_lat(input logic [1:0] sz, input logic [31:0] a);
        if (!m_legal(sz, a)) return 1;
`ifdef DMEM_MISALIGN_EN
        if ((a % 4) + (32'd1 << sz) > 4) return 2;
`endif
        return 1;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = wd[8*i +: 8];
    endfunction

    // ---------------- driver (no checking) ----------------
    // Called just after a rising edge; returns at the same phase.
    task automatic drive_req(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd, output logic er,
                             output int rlow, output logic hi_after);
        int waited;
        cs = 1'b1; req_valid = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        waited = 0;
        while (!req_ready && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        cs = 1'b0; req_valid = 1'b0;
        lat = -1; rd = 'x; er = 1'bx; rlow = 0;
        for (int c = 1; c <= 4 && lat < 0; c++) begin
            if (rsp_valid) begin
                lat = c; rd = rdata; er = err;
            end else begin
                if (!req_ready) rlow++;
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        hi_after = rsp_valid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_init_fill();
        int lat, rlow; logic [31:0] rd, wd; logic er, hi;
        for (int r = 0; r < DEPTH / 4; r++) begin
            wd = $urandom;
            drive_req(1'b1, 2'd2, 1'b0, 32'(4 * r), wd, lat, rd, er, rlow, hi);
            m_store(2'd2, 32'(4 * r), wd);
            n_checks++;
            if (lat !== 1 || er !== 1'b0 || rd !== 32'h0 || hi !== 1'b0)
                $display("FAIL init_store@%0h: lat=%0d err=%b rdata=%h hi=%b expected lat=1 err=0 rdata=0 hi=0", 4 * r, lat, er, rd, hi);
            else n_pass++;
        end
    endtask

    task automatic test_sign_ext();
        int lat, rlow; logic [31:0] rd; logic er, hi;
        drive_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, lat, rd, er, rlow, hi);
        m_store(2'd2, 32'h10, 32'h1122_3344);
        drive_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== 32'h0000_0011 || er !== 1'b0 || lat !== 1)
            $display("FAIL ld_byte_13: rdata=%h err=%b lat=%0d expected 00000011 0 1", rd, er, lat); else n_pass++;
        drive_req(1'b1, 2'd0, 1'b0, 32'h20, 32'hDEAD_BE84, lat, rd, er, rlow, hi);
        m_store(2'd0, 32'h20, 32'hDEAD_BE84);
        drive_req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== 32'hFFFF_FF84) $display("FAIL ld_byte_sext: got %h expected ffffff84", rd); else n_pass++;
        drive_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== 32'h0000_0084) $display("FAIL ld_byte_zext: got %h expected 00000084", rd); else n_pass++;
        drive_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0, lat, rd, er, rlow, hi);
        m_store(2'd0, 32'h21, 32'h0);
        drive_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== 32'h0000_0084) $display("FAIL ld_half_sext: got %h expected 00000084", rd); else n_pass++;
        drive_req(1'b1, 2'd1, 1'b0, 32'h24, 32'h0000_8001, lat, rd, er, rlow, hi);
        m_store(2'd1, 32'h24, 32'h0000_8001);
        drive_req(1'b0, 2'd1, 1'b1, 32'h24, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== 32'hFFFF_8001) $display("FAIL ld_half_neg: got %h expected ffff8001", rd); else n_pass++;
    endtask

    task automatic test_misalign();
        int lat, rlow, elat; logic [31:0] rd, exp; logic er, hi, lg;
        lg = m_legal(2'd2, 32'h0E);
        elat = m_lat(2'd2, 32'h0E);
        drive_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'hAABB_CCDD, lat, rd, er, rlow, hi);
        if (lg) m_store(2'd2, 32'h0E, 32'hAABB_CCDD);
        n_checks++; if (lat !== elat || er !== !lg || rlow !== elat - 1 || hi !== 1'b0)
            $display("FAIL mis_store: lat=%0d err=%b rlow=%0d hi=%b expected lat=%0d err=%b rlow=%0d hi=0", lat, er, rlow, hi, elat, !lg, elat - 1);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, 2'd0, 1'b0, 32'(14 + i), 32'h0, lat, rd, er, rlow, hi);
            n_checks++; if (rd !== {24'h0, ref_mem[14 + i]} || er !== 1'b0)
                $display("FAIL mis_byte@%0h: got %h expected %h", 14 + i, rd, ref_mem[14 + i]); else n_pass++;
        end
        exp = lg ? m_load(2'd2, 1'b0, 32'h0E) : 32'h0;
`ifdef DMEM_MISALIGN_EN
        n_checks++; if (exp !== 32'hAABB_CCDD) $display("FAIL mis_model_bytes: got %h expected aabbccdd", exp); else n_pass++;
`endif
        drive_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== exp || er !== !lg || lat !== elat)
            $display("FAIL mis_load: rdata=%h err=%b lat=%0d expected %h %b %0d", rd, er, lat, exp, !lg, elat); else n_pass++;
    endtask

    task automatic test_range();
        int lat, rlow; logic [31:0] rd; logic er, hi;
        drive_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, lat, rd, er, rlow, hi); // leave non-zero rdata behind
        drive_req(1'b0, 2'd2, 1'b0, 32'hFE, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1)
            $display("FAIL range_word_FE: err=%b rdata=%h lat=%0d expected 1 0 1", er, rd, lat); else n_pass++;
        drive_req(1'b1, 2'd1, 1'b0, 32'hFF, 32'h0000_5A5A ^ {16'h0, ref_mem[255], ref_mem[255]}, lat, rd, er, rlow, hi);
        n_checks++; if (er !== 1'b1) $display("FAIL range_half_FF: err=%b expected 1", er); else n_pass++;
        drive_req(1'b0, 2'd0, 1'b0, 32'hFF, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (rd !== {24'h0, ref_mem[255]} || er !== 1'b0)
            $display("FAIL range_FF_kept: got %h expected %h", rd, ref_mem[255]); else n_pass++;
        drive_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL range_dword: err=%b rdata=%h expected 1 0", er, rd); else n_pass++;
        drive_req(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, lat, rd, er, rlow, hi);
        n_checks++; if (er !== 1'b1) $display("FAIL range_nowrap: err=%b expected 1", er); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] al [5];
        bit          csl [5];
        logic [31:0] exp;
        al  = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h0C};
        csl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 5; s++) begin
            cs = csl[s]; req_valid = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = al[s];
            exp = m_load(2'd2, 1'b0, al[s]);
            @(posedge clk); #1;
            n_checks++;
            if (csl[s]) begin
                if (rsp_valid !== 1'b1 || rdata !== exp || req_ready !== 1'b1)
                    $display("FAIL b2b_slot%0d: rsp_valid=%b rdata=%h expected 1 %h", s, rsp_valid, rdata, exp);
                else n_pass++;
            end else begin
                if (rsp_valid !== 1'b0) $display("FAIL b2b_cs_low: rsp_valid=%b expected 0", rsp_valid);
                else n_pass++;
            end
        end
        cs = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, rlow; logic [31:0] rd, wd; logic er, hi;
`ifdef DMEM_MISALIGN_EN
        wd = ~{ref_mem[33], ref_mem[32], ref_mem[31], ref_mem[30]};
        cs = 1'b1; req_valid = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h1E; wdata = wd;
        @(posedge clk); #1;
        cs = 1'b0; req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_split_busy: req_ready=%b expected 0", req_ready); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_split_rsp0: rsp_valid=%b expected 0", rsp_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_split_rsp1: rsp_valid=%b expected 0", rsp_valid); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rdata !== 32'h0)
            $display("FAIL rst_split_after: ready=%b rsp_valid=%b rdata=%h expected 1 0 0", req_ready, rsp_valid, rdata); else n_pass++;
        ref_mem[30] = wd[7:0];
        ref_mem[31] = wd[15:8];
`else
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0)
            $display("FAIL rst_idle: ready=%b rsp_valid=%b rdata=%h err=%b expected 1 0 0 0", req_ready, rsp_valid, rdata, err); else n_pass++;
`endif
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, 2'd0, 1'b0, 32'(30 + i), 32'h0, lat, rd, er, rlow, hi);
            n_checks++; if (rd !== {24'h0, ref_mem[30 + i]})
                $display("FAIL rst_kept@%0h: got %h expected %h", 30 + i, rd, ref_mem[30 + i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, rlow, elat, r;
        logic [31:0] rd, a, wd, erd;
        logic [1:0] sz;
        logic er, hi, w, sx, lg;
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            if (r == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else        a = 32'($urandom_range(0, DEPTH + 3));
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            w  = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            wd = $urandom;
            lg   = m_legal(sz, a);
            elat = m_lat(sz, a);
            erd  = (lg && !w) ? m_load(sz, sx, a) : 32'h0;
            drive_req(w, sz, sx, a, wd, lat, rd, er, rlow, hi);
            if (lg && w) m_store(sz, a, wd);
            n_checks++; if (lat !== elat)
                $display("FAIL rnd%0d_lat: got %0d expected %0d (we=%b size=%0d addr=%h)", n, lat, elat, w, sz, a); else n_pass++;
            n_checks++; if (er !== !lg || rd !== erd)
                $display("FAIL rnd%0d_data: err=%b rdata=%h expected %b %h (we=%b size=%0d sx=%b addr=%h)", n, er, rd, !lg, erd, w, sz, sx, a); else n_pass++;
            n_checks++; if (rlow !== elat - 1 || hi !== 1'b0)
                $display("FAIL rnd%0d_pulse: ready_low=%0d hi_after=%b expected %0d 0", n, rlow, hi, elat - 1); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_sign_ext();
        test_misalign();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
